junction_ctrl: RTL and testbench
================================

Name: junction_ctrl

Overview:
Two-road junction sequencer that drives two traffic-light heads (north-south main road, east-west side road) plus a pedestrian WALK lamp. It uses per-phase down-counter timers. It latches an east-west vehicle sensor and a pedestrian push-button. The main road rests on green until a request arrives. Each light output uses the same 3-bit rag encoding as the single-light block: bit2 red, bit1 amber, bit0 green.

Parameters:
T_GREEN, 8, minimum green time in cycles for both roads; EW green length is exactly this value.
T_AMBER, 2, amber time in cycles.
T_REDAMBER, 2, red+amber time in cycles.
T_ALLRED, 1, all-red clearance time in cycles.
T_WALK, 6, pedestrian WALK time in cycles.
CTR_W, 8, timer width; every T_* must be >=1 and <=2**CTR_W.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
ew_sense  input  1  east-west vehicle detect; any-length pulse.
ped_req  input  1  pedestrian button; any-length pulse.
rag_ns  output  3  north-south light {red,amber,green}.
rag_ew  output  3  east-west light {red,amber,green}.
walk  output  1  pedestrian WALK lamp.
ped_wait  output  1  pedestrian request latched, not yet served.
phase  output  4  current state code, for debug.

Behaviour:
- One clock domain. State, timer, ew_wait and ped_wait are registers, cleared or loaded asynchronously by rst.
- Outputs are a Moore decode of the state register. There is no extra register stage.
- States, with phase code, duration and outputs (rag_ns/rag_ew/walk):
  - ALLRED_A: 0, T_ALLRED, 100/100/0.
  - WALK: 1, T_WALK, 100/100/1.
  - NS_RA: 2, T_REDAMBER, 110/100/0.
  - NS_G: 3, >=T_GREEN, 001/100/0.
  - NS_A: 4, T_AMBER, 010/100/0.
  - ALLRED_B: 5, T_ALLRED, 100/100/0.
  - EW_RA: 6, T_REDAMBER, 100/110/0.
  - EW_G: 7, T_GREEN, 100/001/0.
  - EW_A: 8, T_AMBER, 100/010/0.
  - Codes 9-15 are unused. If the state register ever holds one, the next edge goes to ALLRED_A.
- Timer:
  - Loaded with T_x-1 on every state entry, including reset.
  - Decrements each cycle; saturates at 0.
  - A state may exit only on an edge where the timer is 0. Every state therefore lasts exactly T_x cycles, except NS_G.
- Transitions:
  - ALLRED_A goes to WALK if ped_wait, else to NS_RA.
  - WALK goes to NS_RA.
  - NS_RA goes to NS_G.
  - NS_G goes to NS_A only when the timer is 0 and (ew_wait | ped_wait). Otherwise it holds NS_G indefinitely with the timer held at 0.
  - NS_A goes to ALLRED_B.
  - ALLRED_B goes to EW_RA if ew_wait, else to ALLRED_A.
  - EW_RA goes to EW_G.
  - EW_G goes to EW_A.
  - EW_A goes to ALLRED_A.
- Request latches:
  - ew_wait (internal) sets on any cycle ew_sense=1. It clears on the edge entering EW_G and stays 0 throughout EW_G; ew_sense during EW_G is ignored. Clear wins over set on the entry edge.
  - ped_wait sets on any cycle ped_req=1. It clears on the edge entering WALK and stays 0 throughout WALK; ped_req during WALK is ignored. Clear wins on the entry edge.
- Latency: a request pulse in cycle k is visible in ped_wait/ew_wait from cycle k+1. If NS_G is resting (timer 0), the state is NS_A from cycle k+2.
- When both requests are pending, service order is EW phase first, then WALK, then NS.
- Safety invariant: never green or amber on both roads at once. walk=1 only when both rag outputs are 100.
- Reset mid-operation:
  - Outputs go to 100/100/0, ped_wait=0 and phase=0 immediately, with no clock edge needed.
  - Both request latches clear; the timer loads T_ALLRED-1.
  - After release, ALLRED_A runs for T_ALLRED cycles.

Test Plan:
1. Hold rst for 3 cycles, then release; no requests. Required: while rst=1, rag_ns=100, rag_ew=100, walk=0, phase=0. After release: 1 cycle phase 0, then rag_ns=110 for 2 cycles, then rag_ns=001 held for 50+ cycles with rag_ew=100.
2. After 20 cycles resting on NS_G, pulse ew_sense for 1 cycle. Required sequence from 2 cycles after the pulse:
   - rag_ns=010 for 2 cycles;
   - all-red for 1 cycle;
   - rag_ew=110 for 2 cycles, then 001 for 8, then 010 for 2;
   - all-red for 1 cycle;
   - rag_ns=110 for 2 cycles, then NS_G rests again.
3. Pulse ped_req 3 cycles into NS_G. Required:
   - ped_wait=1 from the next cycle;
   - NS_G completes the full 8 cycles, then NS_A (2), ALLRED_B (1), ALLRED_A (1);
   - then walk=1 with both lights 100 for 6 cycles and ped_wait=0;
   - then NS_RA.
   - A ped_req pulse inside WALK leaves ped_wait=0 and causes no second WALK.
4. Pulse ew_sense and ped_req in the same cycle during a resting NS_G. Required: EW phase served first (phase 6,7,8), then phase 0, then WALK (phase 1, 6 cycles), then NS_RA. ew_wait and ped_wait each clear exactly once.
5. Assert rst asynchronously mid EW_G (phase 7). Required: outputs become 100/100/0 with ped_wait=0 and phase=0 before the next clock edge. After release the step-1 sequence repeats; the earlier pending requests are lost.
6. Pulse ew_sense during EW_G, then again during EW_A. Required: the first pulse is ignored; the second leaves ew_wait set. After the next NS_G minimum of 8 cycles, EW is served again without any further sensor pulse.

Source files
------------

// File: rtl/junction_ctrl.sv
// Two-road junction sequencer: NS main road rests on green, EW side road and
// pedestrian WALK are served on latched requests using per-phase down-counters.
module junction_ctrl #(
    parameter int unsigned T_GREEN    = 8,
    parameter int unsigned T_AMBER    = 2,
    parameter int unsigned T_REDAMBER = 2,
    parameter int unsigned T_ALLRED   = 1,
    parameter int unsigned T_WALK     = 6,
    parameter int unsigned CTR_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ew_sense,
    input  logic       ped_req,
    output logic [2:0] rag_ns,
    output logic [2:0] rag_ew,
    output logic       walk,
    output logic       ped_wait,
    output logic [3:0] phase
);

    typedef enum logic [3:0] {
        ALLRED_A = 4'd0,
        WALK     = 4'd1,
        NS_RA    = 4'd2,
        NS_G     = 4'd3,
        NS_A     = 4'd4,
        ALLRED_B = 4'd5,
        EW_RA    = 4'd6,
        EW_G     = 4'd7,
        EW_A     = 4'd8
    } state_t;

    localparam logic [CTR_W-1:0] LD_GREEN    = CTR_W'(T_GREEN - 1);
    localparam logic [CTR_W-1:0] LD_AMBER    = CTR_W'(T_AMBER - 1);
    localparam logic [CTR_W-1:0] LD_REDAMBER = CTR_W'(T_REDAMBER - 1);
    localparam logic [CTR_W-1:0] LD_ALLRED   = CTR_W'(T_ALLRED - 1);
    localparam logic [CTR_W-1:0] LD_WALK     = CTR_W'(T_WALK - 1);

    state_t           state;
    logic [CTR_W-1:0] timer;
    logic             ew_wait;
    logic             expired;

    assign expired = (timer == '0);

    // Request latches are set first; the state case below overrides them so
    // that a clear on entry to (and throughout) the serving phase wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ALLRED_A;
            timer    <= LD_ALLRED;
            ew_wait  <= 1'b0;
            ped_wait <= 1'b0;
        end else begin
            if (!expired)
                timer <= timer - CTR_W'(1);
            if (ew_sense)
                ew_wait <= 1'b1;
            if (ped_req)
                ped_wait <= 1'b1;

            case (state)
                ALLRED_A: if (expired) begin
                    if (ped_wait) begin
                        state    <= WALK;
                        timer    <= LD_WALK;
                        ped_wait <= 1'b0;
                    end else begin
                        state <= NS_RA;
                        timer <= LD_REDAMBER;
                    end
                end
                WALK: begin
                    ped_wait <= 1'b0;
                    if (expired) begin
                        state <= NS_RA;
                        timer <= LD_REDAMBER;
                    end
                end
                NS_RA: if (expired) begin
                    state <= NS_G;
                    timer <= LD_GREEN;
                end
                NS_G: if (expired && (ew_wait || ped_wait)) begin
                    state <= NS_A;
                    timer <= LD_AMBER;
                end
                NS_A: if (expired) begin
                    state <= ALLRED_B;
                    timer <= LD_ALLRED;
                end
                ALLRED_B: if (expired) begin
                    if (ew_wait) begin
                        state <= EW_RA;
                        timer <= LD_REDAMBER;
                    end else begin
                        state <= ALLRED_A;
                        timer <= LD_ALLRED;
                    end
                end
                EW_RA: if (expired) begin
                    state   <= EW_G;
                    timer   <= LD_GREEN;
                    ew_wait <= 1'b0;
                end
                EW_G: begin
                    ew_wait <= 1'b0;
                    if (expired) begin
                        state <= EW_A;
                        timer <= LD_AMBER;
                    end
                end
                EW_A: if (expired) begin
                    state <= ALLRED_A;
                    timer <= LD_ALLRED;
                end
                default: begin
                    state <= ALLRED_A;
                    timer <= LD_ALLRED;
                end
            endcase
        end
    end

    always_comb begin
        rag_ns = 3'b100;
        rag_ew = 3'b100;
        walk   = 1'b0;
        case (state)
            WALK:    walk   = 1'b1;
            NS_RA:   rag_ns = 3'b110;
            NS_G:    rag_ns = 3'b001;
            NS_A:    rag_ns = 3'b010;
            EW_RA:   rag_ew = 3'b110;
            EW_G:    rag_ew = 3'b001;
            EW_A:    rag_ew = 3'b010;
            default: ;
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_junction_ctrl.sv
// Cycle-by-cycle vector table for junction_ctrl with an expected-output queue.
module tb_junction_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ew_sense = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] rag_ns;
    logic [2:0] rag_ew;
    logic       walk;
    logic       ped_wait;
    logic [3:0] phase;

    int unsigned errors = 0;
    int unsigned checks = 0;

    junction_ctrl #(
        .T_GREEN   (8),
        .T_AMBER   (2),
        .T_REDAMBER(2),
        .T_ALLRED  (1),
        .T_WALK    (6),
        .CTR_W     (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ew_sense(ew_sense),
        .ped_req (ped_req),
        .rag_ns  (rag_ns),
        .rag_ew  (rag_ew),
        .walk    (walk),
        .ped_wait(ped_wait),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ew;
        logic       ped;
        logic [3:0] ph;
        logic       pw;
    } vec_t;

    typedef struct {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
        logic       pw;
        logic [3:0] ph;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    task automatic add(input int n, input bit r, input int ph, input bit pw,
                       input bit ew = 1'b0, input bit ped = 1'b0);
        vec_t v;
        v.rst = r;
        v.ew  = ew;
        v.ped = ped;
        v.ph  = 4'(ph);
        v.pw  = pw;
        for (int i = 0; i < n; i++)
            vecs.push_back(v);
    endtask

    // Light pattern for each phase code, straight from the phase table.
    function automatic exp_t expect_of(input vec_t v);
        exp_t e;
        e.ns   = 3'b100;
        e.ew   = 3'b100;
        e.walk = 1'b0;
        e.pw   = v.pw;
        e.ph   = v.ph;
        case (v.ph)
            4'd1: e.walk = 1'b1;
            4'd2: e.ns = 3'b110;
            4'd3: e.ns = 3'b001;
            4'd4: e.ns = 3'b010;
            4'd6: e.ew = 3'b110;
            4'd7: e.ew = 3'b001;
            4'd8: e.ew = 3'b010;
            default: ;
        endcase
        return e;
    endfunction

    task automatic check_out(input int idx);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty vec=%0d: no expected entry queued", idx);
            return;
        end
        e = sb.pop_front();
        if ({rag_ns, rag_ew, walk, ped_wait, phase} !== {e.ns, e.ew, e.walk, e.pw, e.ph}) begin
            errors++;
            $display("FAIL vec%0d: got ns=%b ew=%b walk=%b ped_wait=%b phase=%0d, need ns=%b ew=%b walk=%b ped_wait=%b phase=%0d",
                     idx, rag_ns, rag_ew, walk, ped_wait, phase,
                     e.ns, e.ew, e.walk, e.pw, e.ph);
        end
        checks++;
        if ((rag_ns[2] == 1'b0 && rag_ew[2] == 1'b0) ||
            (walk && (rag_ns != 3'b100 || rag_ew != 3'b100))) begin
            errors++;
            $display("FAIL safety vec%0d: got ns=%b ew=%b walk=%b, need no conflicting heads",
                     idx, rag_ns, rag_ew, walk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1);
    end

    initial begin
        // reset held, then release: ALLRED_A 1, NS_RA 2, NS_G resting 50+
        add(3, 1, 0, 0);
        add(1, 0, 0, 0);
        add(2, 0, 2, 0);
        add(57, 0, 3, 0);
        // EW request while resting: NS_A two cycles after the pulse
        add(1, 0, 3, 0, 1, 0);
        add(1, 0, 3, 0);
        add(2, 0, 4, 0); add(1, 0, 5, 0); add(2, 0, 6, 0);
        add(8, 0, 7, 0); add(2, 0, 8, 0); add(1, 0, 0, 0);
        add(2, 0, 2, 0);
        // pedestrian request 3 cycles into NS_G; pulse inside WALK ignored
        add(3, 0, 3, 0);
        add(1, 0, 3, 0, 0, 1);
        add(4, 0, 3, 1);
        add(2, 0, 4, 1); add(1, 0, 5, 1); add(1, 0, 0, 1);
        add(2, 0, 1, 0);
        add(1, 0, 1, 0, 0, 1);
        add(3, 0, 1, 0);
        add(2, 0, 2, 0);
        // both requests together: EW first, then WALK, then NS; sensor in EW_G ignored
        add(11, 0, 3, 0);
        add(1, 0, 3, 0, 1, 1);
        add(1, 0, 3, 1);
        add(2, 0, 4, 1); add(1, 0, 5, 1); add(2, 0, 6, 1);
        add(5, 0, 7, 1);
        add(1, 0, 7, 1, 1, 0);
        add(2, 0, 7, 1);
        add(2, 0, 8, 1); add(1, 0, 0, 1);
        add(6, 0, 1, 0);
        add(2, 0, 2, 0);
        // EW pulse in EW_G ignored, pulse in EW_A re-requests EW after min green
        add(11, 0, 3, 0);
        add(1, 0, 3, 0, 1, 0);
        add(1, 0, 3, 0);
        add(2, 0, 4, 0); add(1, 0, 5, 0); add(2, 0, 6, 0);
        add(3, 0, 7, 0);
        add(1, 0, 7, 0, 1, 0);
        add(4, 0, 7, 0);
        add(1, 0, 8, 0, 1, 0);
        add(1, 0, 8, 0);
        add(1, 0, 0, 0); add(2, 0, 2, 0);
        add(8, 0, 3, 0);
        add(2, 0, 4, 0); add(1, 0, 5, 0); add(2, 0, 6, 0);
        // async reset mid EW_G with a pending ped request, which is lost
        add(1, 0, 7, 0);
        add(1, 0, 7, 0, 0, 1);
        add(2, 0, 7, 1);
        add(2, 1, 0, 0);
        add(1, 0, 0, 0);
        add(2, 0, 2, 0);
        add(20, 0, 3, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            rst      = vecs[i].rst;
            ew_sense = vecs[i].ew;
            ped_req  = vecs[i].ped;
            sb.push_back(expect_of(vecs[i]));
            @(negedge clk);
            check_out(i);
        end

        // hand sequence: async reset seen well before the next clock edge
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        checks++;
        if ({rag_ns, rag_ew, walk, ped_wait, phase} !== {3'b100, 3'b100, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL async_rst: got ns=%b ew=%b walk=%b ped_wait=%b phase=%0d, need 100/100/0/0/0",
                     rag_ns, rag_ew, walk, ped_wait, phase);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries, need 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
